// File: rtl/gerenciador_pool_ativos.sv
// Active-node pool: insert with decrease-key, remove by address, and rounds
// that emit up to NUM_SAIDA minimum-criterio nodes, popped atomically.
module gerenciador_pool_ativos #(
  parameter int NUM_NA          = 8,
  parameter int NUM_SAIDA       = 2,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1,
  parameter int CONT_WIDTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ins_valid_in,
  input  logic                                 rem_valid_in,
  input  logic                                 classificar_in,
  input  logic                                 pop_aprovados_in,
  input  logic [ADDR_WIDTH-1:0]                endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0]           distancia_in,
  input  logic [CUSTO_WIDTH-1:0]               heuristica_in,
  input  logic [ADDR_WIDTH-1:0]                anterior_in,
  output logic                                 ocupado_out,
  output logic                                 pronto_out,
  output logic [NUM_SAIDA-1:0]                 sel_valid_out,
  output logic [ADDR_WIDTH*NUM_SAIDA-1:0]      sel_endereco_out,
  output logic [DISTANCIA_WIDTH*NUM_SAIDA-1:0] sel_distancia_out,
  output logic [ADDR_WIDTH*NUM_SAIDA-1:0]      sel_anterior_out,
  output logic [CRITERIO_WIDTH-1:0]            criterio_min_out,
  output logic [CONT_WIDTH-1:0]                num_ativos_out,
  output logic                                 tem_ativo_out,
  output logic                                 cheio_out,
  output logic                                 overflow_out
);

  localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  typedef enum logic [2:0] {IDLE, ESCREVER, VARRER, SELECIONAR, PRONTO} estado_t;
  estado_t estado;

  logic [NUM_NA-1:0]          ativo;
  logic [ADDR_WIDTH-1:0]      endereco  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] distancia [NUM_NA];
  logic [ADDR_WIDTH-1:0]      anterior  [NUM_NA];
  logic [CRITERIO_WIDTH-1:0]  criterio  [NUM_NA];

  logic [ADDR_WIDTH-1:0]      ins_end;
  logic [DISTANCIA_WIDTH-1:0] ins_dist;
  logic [ADDR_WIDTH-1:0]      ins_ant;
  logic [CRITERIO_WIDTH-1:0]  ins_crit;
  logic                       ins_hit, ins_livre;
  logic [IDX_W-1:0]           ins_idx;

  logic [IDX_W-1:0]           idx_varre;
  logic [CRITERIO_WIDTH-1:0]  crit_varre;
  logic [NUM_NA-1:0]          sel_mask;

  logic                       match_hit, livre_hit;
  logic [IDX_W-1:0]           match_idx, livre_idx;
  logic [CRITERIO_WIDTH-1:0]  crit_novo;
  logic [CONT_WIDTH-1:0]      contagem;

  logic [NUM_NA-1:0]                 mask_n;
  logic [NUM_SAIDA-1:0]              valid_n;
  logic [ADDR_WIDTH*NUM_SAIDA-1:0]      end_n, ant_n;
  logic [DISTANCIA_WIDTH*NUM_SAIDA-1:0] dist_n;
  logic                                 achou;

  assign crit_novo = CRITERIO_WIDTH'(distancia_in) + CRITERIO_WIDTH'(heuristica_in);

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    livre_hit = 1'b0;
    livre_idx = '0;
    contagem  = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (!match_hit && ativo[i] && endereco[i] == endereco_in) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!livre_hit && !ativo[i]) begin
        livre_hit = 1'b1;
        livre_idx = IDX_W'(i);
      end
      contagem = contagem + CONT_WIDTH'(ativo[i]);
    end
  end

  // Lane l takes the lowest-index minimum slot not already claimed by a lower lane.
  always_comb begin
    mask_n  = '0;
    valid_n = '0;
    end_n   = '0;
    ant_n   = '0;
    dist_n  = '0;
    achou   = 1'b0;
    for (int unsigned l = 0; l < NUM_SAIDA; l++) begin
      achou = 1'b0;
      for (int unsigned i = 0; i < NUM_NA; i++) begin
        if (!achou && ativo[i] && !mask_n[i] && criterio[i] == crit_varre) begin
          achou      = 1'b1;
          mask_n[i]  = 1'b1;
          valid_n[l] = 1'b1;
          end_n[l*ADDR_WIDTH +: ADDR_WIDTH]            = endereco[i];
          ant_n[l*ADDR_WIDTH +: ADDR_WIDTH]            = anterior[i];
          dist_n[l*DISTANCIA_WIDTH +: DISTANCIA_WIDTH] = distancia[i];
        end
      end
    end
  end

  assign ocupado_out    = (estado == ESCREVER) || (estado == VARRER) || (estado == SELECIONAR);
  assign num_ativos_out = contagem;
  assign tem_ativo_out  = (contagem != '0);
  assign cheio_out      = (contagem == CONT_WIDTH'(NUM_NA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado            <= IDLE;
      ativo             <= '0;
      for (int unsigned i = 0; i < NUM_NA; i++) begin
        endereco[i]  <= '0;
        distancia[i] <= '0;
        anterior[i]  <= '0;
        criterio[i]  <= '0;
      end
      ins_end           <= '0;
      ins_dist          <= '0;
      ins_ant           <= '0;
      ins_crit          <= '0;
      ins_hit           <= 1'b0;
      ins_livre         <= 1'b0;
      ins_idx           <= '0;
      idx_varre         <= '0;
      crit_varre        <= '1;
      sel_mask          <= '0;
      pronto_out        <= 1'b0;
      sel_valid_out     <= '0;
      sel_endereco_out  <= '0;
      sel_distancia_out <= '0;
      sel_anterior_out  <= '0;
      criterio_min_out  <= '0;
      overflow_out      <= 1'b0;
    end else begin
      case (estado)
        IDLE, PRONTO: begin
          if (pop_aprovados_in && estado == PRONTO) begin
            ativo         <= ativo & ~sel_mask;
            pronto_out    <= 1'b0;
            sel_valid_out <= '0;
            estado        <= IDLE;
          end else if (rem_valid_in) begin
            pronto_out    <= 1'b0;
            sel_valid_out <= '0;
            if (match_hit) ativo[match_idx] <= 1'b0;
            estado        <= IDLE;
          end else if (ins_valid_in) begin
            pronto_out    <= 1'b0;
            sel_valid_out <= '0;
            ins_end       <= endereco_in;
            ins_dist      <= distancia_in;
            ins_ant       <= anterior_in;
            ins_crit      <= crit_novo;
            ins_hit       <= match_hit;
            ins_livre     <= livre_hit;
            ins_idx       <= match_hit ? match_idx : livre_idx;
            estado        <= ESCREVER;
          end else if (classificar_in) begin
            sel_valid_out <= '0;
            if (contagem == '0) begin
              pronto_out       <= 1'b1;
              criterio_min_out <= '1;
              sel_mask         <= '0;
              estado           <= PRONTO;
            end else begin
              pronto_out <= 1'b0;
              idx_varre  <= '0;
              crit_varre <= '1;
              estado     <= VARRER;
            end
          end
        end
        ESCREVER: begin
          if (ins_hit) begin
            if (ins_dist < distancia[ins_idx]) begin
              distancia[ins_idx] <= ins_dist;
              anterior[ins_idx]  <= ins_ant;
              criterio[ins_idx]  <= ins_crit;
            end
          end else if (ins_livre) begin
            ativo[ins_idx]     <= 1'b1;
            endereco[ins_idx]  <= ins_end;
            distancia[ins_idx] <= ins_dist;
            anterior[ins_idx]  <= ins_ant;
            criterio[ins_idx]  <= ins_crit;
          end else begin
            overflow_out <= 1'b1;
          end
          estado <= IDLE;
        end
        VARRER: begin
          if (ativo[idx_varre] && criterio[idx_varre] < crit_varre)
            crit_varre <= criterio[idx_varre];
          idx_varre <= idx_varre + 1'b1;
          if (idx_varre == IDX_W'(NUM_NA - 1)) estado <= SELECIONAR;
        end
        SELECIONAR: begin
          sel_mask          <= mask_n;
          sel_valid_out     <= valid_n;
          sel_endereco_out  <= end_n;
          sel_distancia_out <= dist_n;
          sel_anterior_out  <= ant_n;
          criterio_min_out  <= crit_varre;
          pronto_out        <= 1'b1;
          estado            <= PRONTO;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule
